// File: rtl/aqp_clken_gen.sv
// Multi-channel fractional clock-enable generator: each channel is a phase accumulator whose
// carry is a one-cycle enable pulse; increment changes are staged and applied on a period boundary.
module aqp_clken_gen #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned CH_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 cfg_wr,
    input  logic [CH_BITS-1:0]   cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic [CHANNELS-1:0]  cfg_busy,
    output logic [CHANNELS-1:0]  cfg_done,
    output logic [CHANNELS-1:0]  clken
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CH_BITS-1:0] ChIdx = CH_BITS'(i);

        logic [ACC_WIDTH-1:0] acc_q;
        logic [ACC_WIDTH-1:0] inc_q;
        logic [ACC_WIDTH-1:0] pend_q;
        logic                 pend_v_q;
        logic                 clken_q;
        logic                 done_q;

        logic [ACC_WIDTH:0]   sum;
        logic                 carry;
        logic                 wr_hit;
        logic                 apply;

        always_comb begin
            sum    = {1'b0, acc_q} + {1'b0, inc_q};
            carry  = enable[i] & sum[ACC_WIDTH];
            // cfg_ch values at or above CHANNELS never match any channel index
            wr_hit = cfg_wr && (cfg_ch == ChIdx);
            // A running channel swaps rate only on its carry edge; stopped/idle ones swap at once
            apply  = pend_v_q && (carry || (inc_q == '0) || !enable[i]);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q    <= '0;
                inc_q    <= '0;
                pend_q   <= '0;
                pend_v_q <= 1'b0;
                clken_q  <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                acc_q   <= enable[i] ? sum[ACC_WIDTH-1:0] : '0;
                clken_q <= carry;
                done_q  <= apply;
                if (apply) begin
                    inc_q    <= pend_q;
                    pend_v_q <= 1'b0;
                end
                // A write on the apply edge restages rather than being lost
                if (wr_hit) begin
                    pend_q   <= cfg_inc;
                    pend_v_q <= 1'b1;
                end
            end
        end

        assign clken[i]    = clken_q;
        assign cfg_busy[i] = pend_v_q;
        assign cfg_done[i] = done_q;
    end

endmodule

// File: tb/tb_aqp_clken_gen.sv
// Self-checking bench for aqp_clken_gen: directed scenarios plus randomized traffic, all
// checked against a total-phase reference model of each channel.
module tb_aqp_clken_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  enable = 2'b00;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_inc = 16'd0;
    logic [1:0]  cfg_busy;
    logic [1:0]  cfg_done;
    logic [1:0]  clken;

    int n_pass = 0;
    int n_total = 0;

    aqp_clken_gen #(
        .CHANNELS (2),
        .ACC_WIDTH(16),
        .CH_BITS  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .clken   (clken)
    );

    always #5 clk = ~clk;

    // Model: phase is the total increment accumulated since the last restart; a pulse is
    // emitted whenever that total crosses a multiple of 2^16.
    typedef struct packed {
        longint      phase;
        int unsigned inc;
        int unsigned pend;
        bit          pv;
        bit          pulse;
        bit          done;
    } ch_t;

    ch_t m [2] = '{default: '0};

    function automatic ch_t step(ch_t s, bit rst, bit en, bit hit, int unsigned val);
        ch_t n;
        bit  carry;
        n = s;
        if (rst) return ch_t'(0);
        carry   = en && (((s.phase + longint'(s.inc)) / 65536) != (s.phase / 65536));
        n.phase = en ? s.phase + longint'(s.inc) : 64'sd0;
        n.pulse = carry;
        n.done  = s.pv && (carry || s.inc == 0 || !en);
        if (n.done) begin
            n.inc = s.pend;
            n.pv  = 1'b0;
        end
        if (hit) begin
            n.pend = val;
            n.pv   = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            m[c] <= step(m[c], reset, enable[c], cfg_wr && (cfg_ch == 2'(c)), 32'(cfg_inc));
    end

    logic [5:0] act;
    logic [5:0] exp_out;
    assign act = {clken, cfg_busy, cfg_done};
    always_comb exp_out = {m[1].pulse, m[0].pulse, m[1].pv, m[0].pv, m[1].done, m[0].done};

    task automatic test_reset();
        reset  = 1'b1;
        enable = 2'b11;
        cfg_ch = 2'd0;
        cfg_inc = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cfg_wr = ~cfg_wr;
        end
        @(negedge clk);
        reset  = 1'b0;
        cfg_wr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_total++;
            if (act !== 6'b0) $display("FAIL reset_idle cycle %0d: got %b, want 000000", i, act);
            else n_pass++;
        end
    endtask

    task automatic test_div2();
        int pulses = 0;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h8000;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_total++;
        if ({cfg_done[0], cfg_busy[0]} !== 2'b01)
            $display("FAIL div2_busy_rise: done/busy got %b, want 01", {cfg_done[0], cfg_busy[0]});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({cfg_done[0], cfg_busy[0]} !== 2'b10)
            $display("FAIL div2_apply: done/busy got %b, want 10", {cfg_done[0], cfg_busy[0]});
        else n_pass++;
        for (int i = 0; i < 1004; i++) begin
            @(negedge clk);
            if (i >= 4) pulses += int'(clken[0]);
            n_total++;
            if (act !== exp_out) $display("FAIL div2_model: got %b, want %b", act, exp_out);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 500) $display("FAIL div2_count: got %0d pulses, want 500", pulses);
        else n_pass++;
    endtask

    task automatic test_pixel();
        int pulses = 0;
        int last = -1;
        int max_gap = 0;
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd57614;
        @(negedge clk);
        cfg_wr = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            n_total++;
            if (act !== exp_out) $display("FAIL pixel_model: got %b, want %b", act, exp_out);
            else n_pass++;
            if (i >= 4 && clken[1]) begin
                pulses++;
                if (last >= 0 && i - last > max_gap) max_gap = i - last;
                last = i;
            end
        end
        n_total++;
        if (pulses !== 57614) $display("FAIL pixel_count: got %0d pulses, want 57614", pulses);
        else n_pass++;
        n_total++;
        if (max_gap > 2) $display("FAIL pixel_gap: got max gap %0d, want <= 2", max_gap);
        else n_pass++;
    endtask

    task automatic test_live_switch();
        int  k;
        int  last = -1;
        bit  wrote = 1'b0;
        bit  watch = 1'b0;
        bit  after = 1'b0;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h4000;
        @(negedge clk);
        cfg_wr = 1'b0;
        for (k = 0; k < 4 && !cfg_done[0]; k++) @(negedge clk);
        n_total++;
        if (!cfg_done[0]) $display("FAIL live_setup_timeout: done got 0, want 1");
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_total++;
            if (act !== exp_out) $display("FAIL live_model: got %b, want %b", act, exp_out);
            else n_pass++;
            if (cfg_wr) begin
                cfg_wr = 1'b0;
                watch  = 1'b1;
            end
            if (watch) begin
                n_total++;
                if (cfg_done[0]) begin
                    watch = 1'b0;
                    if (clken[0] !== 1'b1) $display("FAIL live_done_clken: clken got 0, want 1");
                    else n_pass++;
                end else begin
                    if (cfg_busy[0] !== 1'b1) $display("FAIL live_busy_hold: busy got 0, want 1");
                    else n_pass++;
                end
            end
            if (clken[0]) begin
                if (last >= 0) begin
                    n_total++;
                    if (i - last !== (after ? 2 : 4))
                        $display("FAIL live_interval: got %0d, want %0d", i - last, after ? 2 : 4);
                    else n_pass++;
                end
                if (cfg_done[0] && wrote) after = 1'b1;
                last = i;
                if (!wrote && i >= 12) begin
                    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h8000;
                    wrote = 1'b1;
                end
            end
        end
        n_total++;
        if (!after) $display("FAIL live_switch_seen: switch applied got 0, want 1");
        else n_pass++;
    endtask

    task automatic test_collision();
        int k;
        for (k = 0; k < 4 && !clken[0]; k++) @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h4000;
        @(negedge clk);
        cfg_inc = 16'h2000;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_total++;
        if ({cfg_done[0], clken[0], cfg_busy[0]} !== 3'b111)
            $display("FAIL coll_apply: done/clken/busy got %b, want 111",
                     {cfg_done[0], clken[0], cfg_busy[0]});
        else n_pass++;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_total++;
            if (act !== exp_out) $display("FAIL coll_model: got %b, want %b", act, exp_out);
            else n_pass++;
            if (cfg_done[0]) break;
        end
        n_total++;
        if (k !== 4 || {clken[0], cfg_busy[0]} !== 2'b10)
            $display("FAIL coll_second_apply: after %0d cycles clken/busy %b, want 4 cycles 10",
                     k, {clken[0], cfg_busy[0]});
        else n_pass++;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (clken[0]) break;
        end
        n_total++;
        if (k !== 8) $display("FAIL coll_new_rate: interval got %0d, want 8", k);
        else n_pass++;
    endtask

    task automatic test_range();
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'h1234;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_total++;
        if (cfg_busy !== 2'b00) $display("FAIL range_busy: got %b, want 00", cfg_busy);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_total++;
            if (act !== exp_out) $display("FAIL range_model: got %b, want %b", act, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_enable_restart();
        int k;
        enable[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (clken[1] !== 1'b0) $display("FAIL en_off: clken[1] got 1, want 0");
            else n_pass++;
        end
        enable[1] = 1'b1;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (clken[1]) break;
        end
        n_total++;
        if (k !== 2) $display("FAIL en_restart: first pulse after %0d cycles, want 2", k);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        for (k = 0; k < 10 && !clken[0]; k++) @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h8000;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_total++;
        if (cfg_busy[0] !== 1'b1) $display("FAIL rstmid_busy: got 0, want 1");
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_total++;
            if (act !== 6'b0) $display("FAIL rstmid_idle cycle %0d: got %b, want 000000", i, act);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n_total++;
            if (act !== exp_out) $display("FAIL rand_model cycle %0d: got %b, want %b", i, act, exp_out);
            else n_pass++;
            cfg_wr  = ($urandom_range(0, 3) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_inc = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 19) == 0) enable[c] = ~enable[c];
            reset = ($urandom_range(0, 299) == 0);
        end
        reset  = 1'b0;
        cfg_wr = 1'b0;
        @(negedge clk);
        n_total++;
        if (act !== exp_out) $display("FAIL rand_final: got %b, want %b", act, exp_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_div2();
        test_pixel();
        test_live_switch();
        test_collision();
        test_range();
        test_enable_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
